// File: rtl/sram_rmw_port_if.sv
// Request/response bundle between a requester and sram_rmw_port.
// The requester drives the master side; the port itself is the slave.
interface sram_rmw_port_if #(
  parameter int AW    = 9,
  parameter int WIDTH = 56
);
  localparam int BYTES = WIDTH / 8;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [BYTES-1:0] req_wmask;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_rmw_port.sv
// Valid/ready front end for sram_sp: byte-masked writes via
// read-modify-write, 1-cycle reads, optional zero-fill after reset.
module sram_rmw_port #(
  parameter int DEPTH          = 512,
  parameter int WIDTH          = 56,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int BYTES         = WIDTH / 8
) (
  input  logic             clk,
  input  logic             resetn,
  sram_rmw_port_if.slave   req,
  output logic             busy,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_MERGE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [BYTES-1:0] r_mask;
  logic [WIDTH-1:0] r_hold;
  logic             r_pend;

  logic             w_fire;
  logic             w_full;
  logic             w_none;
  logic             w_part;
  logic [WIDTH-1:0] w_merged;

  assign req.req_ready = resetn && (r_state == S_IDLE);
  assign busy          = (r_state == S_CLEAR);

  assign w_fire = req.req_valid & req.req_ready;
  assign w_full = &req.req_wmask;
  assign w_none = ~|req.req_wmask;
  assign w_part = w_fire & req.req_we & ~w_full & ~w_none;

  // mem_dout holds the old word read during the accept cycle
  always_comb begin
    w_merged = mem_dout;
    for (int j = 0; j < BYTES; j++) begin
      if (r_mask[j]) w_merged[j*8 +: 8] = r_wdata[j*8 +: 8];
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = req.req_addr;
    mem_din  = '0;
    unique case (r_state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_cnt;
      end
      S_IDLE: begin
        if (w_fire && req.req_we && w_full) begin
          mem_we  = 1'b1;
          mem_din = req.req_wdata;
        end
      end
      S_MERGE: begin
        mem_we   = 1'b1;
        mem_addr = r_addr;
        mem_din  = w_merged;
      end
      default: ;
    endcase
    // a reset cycle must never disturb the array
    if (!resetn) begin
      mem_we  = 1'b0;
      mem_din = '0;
    end
  end

  assign req.rsp_valid = r_pend;
  assign req.rsp_rdata = r_pend ? mem_dout : r_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_hold  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_fire & ~req.req_we;
      if (r_pend) r_hold <= mem_dout;
      unique case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_part) begin
            r_addr  <= req.req_addr;
            r_wdata <= req.req_wdata;
            r_mask  <= req.req_wmask;
            r_state <= S_MERGE;
          end
        end
        S_MERGE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rmw_port.sv
// Scoreboard bench for sram_rmw_port with a behavioural sram_sp
// and a word-array reference model.
module tb_sram_rmw_port;

  localparam int DEPTH = 512;
  localparam int WIDTH = 56;
  localparam int AW    = 9;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_rmw_port_if #(.AW(AW), .WIDTH(WIDTH)) rq ();
  sram_rmw_port_if #(.AW(AW), .WIDTH(WIDTH)) rq1 ();

  logic             busy, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din, mem_dout;

  logic             busy1, mem_we1;
  logic [AW-1:0]    mem_addr1;
  logic [WIDTH-1:0] mem_din1;
  logic [WIDTH-1:0] mem_dout1 = '0;

  sram_rmw_port #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .CLEAR_ON_RESET(1)
  ) u_dut (
    .clk(clk), .resetn(resetn), .req(rq),
    .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  sram_rmw_port #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .CLEAR_ON_RESET(0)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .req(rq1),
    .busy(busy1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_din(mem_din1), .mem_dout(mem_dout1)
  );

  // behavioural sram_sp: synchronous read, write-without-read
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    else        mem_dout <= mem[mem_addr];
  end

  logic [WIDTH-1:0] ref_mem [DEPTH];
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit busy1_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy1) busy1_seen = 1;
    if (rq.rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 64'(rq.rsp_rdata), 64'hdead);
      end else begin
        e = q.pop_front();
        chk("rsp_data", 64'(rq.rsp_rdata), 64'(e.d));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic we, input logic [AW-1:0] a,
                                input logic [WIDTH-1:0] d,
                                input logic [6:0] m);
    exp_t e;
    if (!we) begin
      e.d   = ref_mem[a];
      e.due = cyc + 1;
      q.push_back(e);
    end else begin
      for (int j = 0; j < 7; j++)
        if (m[j]) ref_mem[a][j*8 +: 8] = d[j*8 +: 8];
    end
  endfunction

  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d, input logic [6:0] m);
    int n = 0;
    rq.req_valid = 1'b1;
    rq.req_we    = we;
    rq.req_addr  = a;
    rq.req_wdata = d;
    rq.req_wmask = m;
    @(negedge clk);
    while (!rq.req_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    if (n >= 10) chk("ready_timeout", 64'(n), 64'd0);
    else model(we, a, d, m);
    step();
    rq.req_valid = 1'b0;
  endtask

  task automatic sweep(input bit chk1);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (!(busy && mem_we && mem_addr == AW'(i) &&
            mem_din == '0 && !rq.req_ready)) begin
        bad++;
        if (first < 0) first = i;
      end
      if (chk1 && i == 0) begin
        chk("c0_ready1", 64'(rq1.req_ready), 64'd1);
        chk("c0_we1", 64'(mem_we1), 64'd1);
        chk("c0_addr1", 64'(mem_addr1), 64'd3);
      end
    end
    chk("sweep_bad_cycles", 64'(bad), 64'd0);
    if (bad != 0) $display("  first bad sweep index %0d", first);
    @(negedge clk);
    chk("ready_after_sweep", 64'(rq.req_ready), 64'd1);
    chk("busy_after_sweep", 64'(busy), 64'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    step();
  endtask

  initial begin
    logic [63:0] r64;
    logic [6:0]  m;
    int sel;
    for (int i = 0; i < DEPTH; i++) begin
      r64 = {$urandom, $urandom};
      mem[i] = r64[WIDTH-1:0];
    end
    rq.req_valid  = 1'b0;
    rq.req_we     = 1'b0;
    rq.req_addr   = '0;
    rq.req_wdata  = '0;
    rq.req_wmask  = '0;
    rq1.req_valid = 1'b1;
    rq1.req_we    = 1'b1;
    rq1.req_addr  = 9'd3;
    rq1.req_wdata = 56'hA5A5A5A5A5A5A5;
    rq1.req_wmask = 7'h7F;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(rq.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rq.rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rq.rsp_rdata), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_ready1", 64'(rq1.req_ready), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    sweep(1'b1);
    rq1.req_valid = 1'b0;

    send(1'b0, 9'h1FF, '0, '0);
    send(1'b1, 9'd5, 56'h123456789ABCDE, 7'h7F);
    send(1'b0, 9'd5, '0, '0);

    send(1'b1, 9'd9, 56'h00112233445566, 7'h7F);
    send(1'b1, 9'd9, 56'hFFFFFFFFFFFFFF, 7'b0000101);
    @(negedge clk);
    chk("merge_ready_low", 64'(rq.req_ready), 64'd0);
    chk("merge_we", 64'(mem_we), 64'd1);
    chk("merge_addr", 64'(mem_addr), 64'd9);
    chk("merge_din", 64'(mem_din), 64'h00112233FF55FF);
    @(negedge clk);
    chk("merge_ready_back", 64'(rq.req_ready), 64'd1);
    step();
    send(1'b0, 9'd9, '0, '0);

    send(1'b1, 9'd1, 56'h11111111111111, 7'h7F);
    send(1'b1, 9'd2, 56'h22222222222222, 7'h7F);
    send(1'b1, 9'd3, 56'h33333333333333, 7'h7F);
    send(1'b0, 9'd1, '0, '0);
    send(1'b0, 9'd2, '0, '0);
    send(1'b0, 9'd3, '0, '0);
    send(1'b1, 9'd2, 56'hEEEEEEEEEEEEEE, 7'h00);
    send(1'b0, 9'd2, '0, '0);
    send(1'b0, 9'd1, '0, '0);
    send(1'b1, 9'd1, 56'h0F0F0F0F0F0F0F, 7'h30);
    send(1'b0, 9'd1, '0, '0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        sel = $urandom_range(0, 3);
        m = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h7F : 7'($urandom);
        r64 = {$urandom, $urandom};
        send(1'($urandom), 9'($urandom_range(0, 15)), r64[WIDTH-1:0], m);
      end
    end
    repeat (3) step();

    send(1'b1, 9'd7, 56'hABABABABABABAB, 7'h0F);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_merge_we", 64'(mem_we), 64'd0);
    chk("rst_merge_ready", 64'(rq.req_ready), 64'd0);
    step();
    step();
    resetn = 1'b1;
    sweep(1'b0);
    send(1'b0, 9'd7, '0, '0);
    repeat (3) step();

    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("busy1_never", 64'(busy1_seen), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
